// File: rtl/ibuf_tile_sequencer.sv
// Tile sequencer: fetches four column words from tile memory, loads them into the
// input buffer, holds START_CALC for the row-shift phase, drains, then pulses DONE.
module ibuf_tile_sequencer #(
    parameter int ADDR_W    = 10,
    parameter int CALC_CYC  = 4,
    parameter int DRAIN_CYC = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [3:0]        ODST_CFG,
    output logic              BUSY,
    output logic              DONE,
    output logic              MEM_REN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [31:0]       MEM_RDATA,
    output logic              LOAD_EN,
    output logic [1:0]        ICOL,
    output logic [31:0]       IWord,
    output logic              START_CALC,
    output logic [3:0]        ODST
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_CALC,
        S_DRAIN,
        S_FIN
    } state_t;

    localparam int CALC_W  = (CALC_CYC > 1) ? $clog2(CALC_CYC) : 1;
    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CALC_W-1:0]  CALC_LOAD  = CALC_W'(CALC_CYC - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = (DRAIN_CYC > 0) ? DRAIN_W'(DRAIN_CYC - 1) : '0;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mem_ren_q, mem_ren_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                load_en_q, load_en_d;
    logic [1:0]          icol_q, icol_d;
    logic [1:0]          col_q, col_d;
    logic                start_calc_q, start_calc_d;
    logic [3:0]          odst_q, odst_d;
    logic [CALC_W-1:0]   calc_cnt_q, calc_cnt_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;

    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        mem_ren_d    = 1'b0;
        mem_addr_d   = '0;
        col_d        = col_q;
        start_calc_d = 1'b0;
        odst_d       = odst_q;
        calc_cnt_d   = calc_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        // Buffer write strobe trails the memory read by the one-cycle read latency.
        load_en_d    = mem_ren_q;
        icol_d       = mem_ren_q ? col_q : 2'd0;

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d    = S_FETCH;
                    mem_ren_d  = 1'b1;
                    mem_addr_d = BASE_ADDR;
                    col_d      = 2'd0;
                    odst_d     = ODST_CFG;
                end
            end
            S_FETCH: begin
                if (col_q == 2'd3) begin
                    state_d = S_LAST;
                end else begin
                    mem_ren_d  = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    col_d      = col_q + 2'd1;
                end
            end
            S_LAST: begin
                state_d      = S_CALC;
                start_calc_d = 1'b1;
                calc_cnt_d   = CALC_LOAD;
            end
            S_CALC: begin
                if (calc_cnt_q == '0) begin
                    if (DRAIN_CYC == 0) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
                    end
                end else begin
                    calc_cnt_d   = calc_cnt_q - CALC_W'(1);
                    start_calc_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                odst_d  = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                odst_d  = 4'd0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mem_ren_q    <= 1'b0;
            mem_addr_q   <= '0;
            load_en_q    <= 1'b0;
            icol_q       <= 2'd0;
            col_q        <= 2'd0;
            start_calc_q <= 1'b0;
            odst_q       <= 4'd0;
            calc_cnt_q   <= '0;
            drain_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mem_ren_q    <= mem_ren_d;
            mem_addr_q   <= mem_addr_d;
            load_en_q    <= load_en_d;
            icol_q       <= icol_d;
            col_q        <= col_d;
            start_calc_q <= start_calc_d;
            odst_q       <= odst_d;
            calc_cnt_q   <= calc_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
        end
    end

    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign MEM_REN    = mem_ren_q;
    assign MEM_ADDR   = mem_addr_q;
    assign LOAD_EN    = load_en_q;
    assign ICOL       = icol_q;
    assign IWord      = load_en_q ? MEM_RDATA : '0;
    assign START_CALC = start_calc_q;
    assign ODST       = odst_q;

endmodule

// File: tb/tb_ibuf_tile_sequencer.sv
// Bench for ibuf_tile_sequencer: scoreboarded memory reads/column loads plus per-cycle
// timing of the control outputs, on the default build and two reduced-timing builds.
module tb_ibuf_tile_sequencer;

    typedef struct packed {
        logic [1:0]  col;
        logic [31:0] word;
    } ld_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        start_v = 1'b0;
    logic [9:0]  BASE_ADDR = '0;
    logic [3:0]  ODST_CFG = '0;
    logic [31:0] MEM_RDATA = '0;
    logic [31:0] rdata_v = '0;

    logic        BUSY, DONE, MEM_REN, LOAD_EN, START_CALC;
    logic [9:0]  MEM_ADDR;
    logic [1:0]  ICOL;
    logic [31:0] IWord;
    logic [3:0]  ODST;

    logic        d0_busy, d0_done, d0_ren, d0_load, d0_calc;
    logic [9:0]  d0_addr;
    logic [1:0]  d0_icol;
    logic [31:0] d0_iword;
    logic [3:0]  d0_odst;

    logic        c1_busy, c1_done, c1_ren, c1_load, c1_calc;
    logic [9:0]  c1_addr;
    logic [1:0]  c1_icol;
    logic [31:0] c1_iword;
    logic [3:0]  c1_odst;

    logic [31:0] mem [1024];
    logic [9:0]  rd_q[$];
    ld_t         ld_q[$];
    int          total = 0;
    int          bad   = 0;

    always #5 CLK = ~CLK;

    ibuf_tile_sequencer #(.ADDR_W(10), .CALC_CYC(4), .DRAIN_CYC(7)) dut (
        .CLK(CLK), .RST(RST), .START(START), .BASE_ADDR(BASE_ADDR), .ODST_CFG(ODST_CFG),
        .BUSY(BUSY), .DONE(DONE), .MEM_REN(MEM_REN), .MEM_ADDR(MEM_ADDR),
        .MEM_RDATA(MEM_RDATA), .LOAD_EN(LOAD_EN), .ICOL(ICOL), .IWord(IWord),
        .START_CALC(START_CALC), .ODST(ODST)
    );

    ibuf_tile_sequencer #(.ADDR_W(10), .CALC_CYC(4), .DRAIN_CYC(0)) dut_d0 (
        .CLK(CLK), .RST(RST), .START(start_v), .BASE_ADDR(BASE_ADDR), .ODST_CFG(ODST_CFG),
        .BUSY(d0_busy), .DONE(d0_done), .MEM_REN(d0_ren), .MEM_ADDR(d0_addr),
        .MEM_RDATA(rdata_v), .LOAD_EN(d0_load), .ICOL(d0_icol), .IWord(d0_iword),
        .START_CALC(d0_calc), .ODST(d0_odst)
    );

    ibuf_tile_sequencer #(.ADDR_W(10), .CALC_CYC(1), .DRAIN_CYC(7)) dut_c1 (
        .CLK(CLK), .RST(RST), .START(start_v), .BASE_ADDR(BASE_ADDR), .ODST_CFG(ODST_CFG),
        .BUSY(c1_busy), .DONE(c1_done), .MEM_REN(c1_ren), .MEM_ADDR(c1_addr),
        .MEM_RDATA(rdata_v), .LOAD_EN(c1_load), .ICOL(c1_icol), .IWord(c1_iword),
        .START_CALC(c1_calc), .ODST(c1_odst)
    );

    // Tile memory with one-cycle read latency.
    always @(posedge CLK) begin
        if (MEM_REN) MEM_RDATA <= mem[MEM_ADDR];
    end

    // Expected {BUSY,DONE,MEM_REN,LOAD_EN,START_CALC,ODST} in cycle k after the accepting edge.
    function automatic logic [8:0] exp_vec(int k, int cc, int dc, logic [3:0] cfg);
        int   fin;
        logic b;
        fin = 6 + cc + dc;
        b   = (k >= 1) && (k <= fin);
        return {b, (k == fin), (k >= 1 && k <= 4), (k >= 2 && k <= 5),
                (k >= 6 && k <= 5 + cc), (b ? cfg : 4'd0)};
    endfunction

    task automatic push_tile(input logic [9:0] base);
        logic [9:0] a;
        for (int i = 0; i < 4; i++) begin
            a = base + 10'(i);
            rd_q.push_back(a);
            ld_q.push_back({2'(i), mem[a]});
        end
    endtask

    task automatic sb_check();
        logic [9:0] ea;
        ld_t        el;
        if (MEM_REN === 1'b1) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: addr=%h required=none", MEM_ADDR);
            end else begin
                ea = rd_q.pop_front();
                if (MEM_ADDR !== ea) begin
                    bad++;
                    $display("FAIL rd_addr: got=%h required=%h", MEM_ADDR, ea);
                end
            end
        end
        if (LOAD_EN === 1'b1) begin
            total++;
            if (ld_q.size() == 0) begin
                bad++;
                $display("FAIL ld_unexpected: icol=%0d word=%h required=none", ICOL, IWord);
            end else begin
                el = ld_q.pop_front();
                if ({ICOL, IWord} !== {el.col, el.word}) begin
                    bad++;
                    $display("FAIL ld_data: got icol=%0d word=%h required icol=%0d word=%h",
                             ICOL, IWord, el.col, el.word);
                end
            end
        end else begin
            total++;
            if (IWord !== 32'd0) begin
                bad++;
                $display("FAIL iword_idle: got=%h required=0", IWord);
            end
        end
    endtask

    task automatic check_vec(input string name, input int k, input logic [8:0] got,
                             input logic [8:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got=%b required=%b", name, k, got, exp);
        end
    endtask

    task automatic check_drained(input string name);
        total++;
        if (rd_q.size() != 0 || ld_q.size() != 0) begin
            bad++;
            $display("FAIL %s_pending: got rd=%0d ld=%0d required rd=0 ld=0",
                     name, rd_q.size(), ld_q.size());
        end
        rd_q.delete();
        ld_q.delete();
    endtask

    task automatic run_tile(input string name, input logic [9:0] base, input logic [3:0] cfg);
        @(negedge CLK);
        START = 1'b1;
        BASE_ADDR = base;
        ODST_CFG = cfg;
        push_tile(base);
        @(posedge CLK);
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                START = 1'b0;
                BASE_ADDR = ~base;
                ODST_CFG = ~cfg;
            end
            check_vec(name, k, {BUSY, DONE, MEM_REN, LOAD_EN, START_CALC, ODST},
                      exp_vec(k, 4, 7, cfg));
            sb_check();
        end
        check_drained(name);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        START = 1'b1;
        BASE_ADDR = 10'h155;
        ODST_CFG = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check_vec("reset", i, {BUSY, DONE, MEM_REN, LOAD_EN, START_CALC, ODST}, 9'd0);
            total++;
            if ({MEM_ADDR, ICOL} !== 12'd0) begin
                bad++;
                $display("FAIL reset_addr_icol: got=%h required=0", {MEM_ADDR, ICOL});
            end
            sb_check();
        end
        START = 1'b0;
        RST = 1'b0;
    endtask

    task automatic test_single();
        run_tile("single", 10'h010, 4'b0101);
    endtask

    task automatic test_wrap();
        run_tile("wrap", 10'h3FE, 4'h3);
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        START = 1'b1;
        BASE_ADDR = 10'h100;
        ODST_CFG = 4'hA;
        for (int t = 0; t < 3; t++) push_tile(10'h100);
        @(posedge CLK);
        for (int k = 1; k <= 54; k++) begin
            @(negedge CLK);
            if (k == 3 || k == 21) begin
                BASE_ADDR = 10'h2AA;
                ODST_CFG = 4'hF;
            end
            if (k == 17 || k == 35) begin
                BASE_ADDR = 10'h100;
                ODST_CFG = 4'hA;
            end
            check_vec("b2b", k, {BUSY, DONE, MEM_REN, LOAD_EN, START_CALC, ODST},
                      exp_vec(((k - 1) % 18) + 1, 4, 7, 4'hA));
            sb_check();
            if (k == 54) START = 1'b0;
        end
        check_drained("b2b");
    endtask

    task automatic test_mid_reset();
        @(negedge CLK);
        START = 1'b1;
        BASE_ADDR = 10'h020;
        ODST_CFG = 4'h6;
        push_tile(10'h020);
        @(posedge CLK);
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            if (k == 1) START = 1'b0;
            check_vec("midrst_pre", k, {BUSY, DONE, MEM_REN, LOAD_EN, START_CALC, ODST},
                      exp_vec(k, 4, 7, 4'h6));
            sb_check();
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 8; k <= 25; k++) begin
            if (k > 8) @(negedge CLK);
            check_vec("midrst_post", k, {BUSY, DONE, MEM_REN, LOAD_EN, START_CALC, ODST}, 9'd0);
            sb_check();
        end
        check_drained("midrst");
        run_tile("after_rst", 10'h040, 4'h9);
    endtask

    task automatic test_variants();
        @(negedge CLK);
        start_v = 1'b1;
        ODST_CFG = 4'hC;
        BASE_ADDR = 10'h080;
        @(posedge CLK);
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            if (k == 1) start_v = 1'b0;
            check_vec("drain0", k, {d0_busy, d0_done, d0_ren, d0_load, d0_calc, d0_odst},
                      exp_vec(k, 4, 0, 4'hC));
            check_vec("calc1", k, {c1_busy, c1_done, c1_ren, c1_load, c1_calc, c1_odst},
                      exp_vec(k, 1, 7, 4'hC));
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {6'(i), 16'hC35A, 10'(i)} ^ 32'h5A5A_0000;
        for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA000_0000 + 32'(i);
        test_reset();
        test_single();
        test_wrap();
        test_back_to_back();
        test_mid_reset();
        test_variants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
